mem_store_unit: RTL and testbench

- Write-side counterpart of the execute-stage load extraction path: accepts store instructions (opselect MEM_WRITE = 3'b100) from execute.
- Formats byte/half/word data onto the proper byte lanes with byte enables.
- Buffers the formatted stores in a small queue and drives them to data memory over a req/ack handshake.
- Sits between execute and the data-memory port; asserts stall back to the pipeline when the queue is full.

---
 rtl/mem_store_unit.sv | 153 +++++++++++++++
 tb/tb_mem_store_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// Store path from execute to data memory: formats byte/half/word stores onto
// byte lanes, queues them, and issues them one at a time over a req/ack port.
module mem_store_unit #(
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  enable,
   input  logic [2:0]            opselect,
   input  logic [2:0]            operation,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [31:0]           st_data,
   output logic                  stall,
   output logic                  misalign_err,
   output logic                  sq_empty,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [2:0] OP_MEM_WRITE = 3'b100;
   localparam logic [2:0] SZ_BYTE      = 3'b000;
   localparam logic [2:0] SZ_HALF      = 3'b001;
   localparam logic [2:0] SZ_WORD      = 3'b011;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
   logic [31:0]           q_wdata [DEPTH];
   logic [3:0]            q_be    [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [1:0]       state;

   logic        offer;
   logic        push;
   logic        pop;
   logic        fmt_legal;
   logic [31:0] fmt_wdata;
   logic [3:0]  fmt_be;
   logic [1:0]  lane;

   assign offer = enable && (opselect == OP_MEM_WRITE);
   assign lane  = st_addr[1:0];

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      fmt_legal = 1'b0;
      fmt_wdata = st_data;
      fmt_be    = 4'b0000;
      case (operation)
         SZ_BYTE: begin
            fmt_legal = 1'b1;
            fmt_wdata = {4{st_data[7:0]}};
            fmt_be    = 4'b0001 << lane;
         end
         SZ_HALF: begin
            fmt_legal = ~lane[0];
            fmt_wdata = {2{st_data[15:0]}};
            fmt_be    = lane[1] ? 4'b1100 : 4'b0011;
         end
         SZ_WORD: begin
            fmt_legal = (lane == 2'b00);
            fmt_wdata = st_data;
            fmt_be    = 4'b1111;
         end
         default: fmt_legal = 1'b0;
      endcase
   end

   // A full queue refuses the offer even when the head retires this cycle.
   assign stall    = (count == CNT_FULL);
   assign push     = offer && fmt_legal && !stall;
   assign pop      = (state == ST_REQ) && mem_ack;
   assign sq_empty = (count == '0) && (state == ST_IDLE);

   // NOTE: queue storage has no reset; only the pointers and count do, and a
   // slot is never read before it has been written.
   always_ff @(posedge CLOCK) begin
      if (push) begin
         q_addr[tail]  <= {st_addr[ADDR_WIDTH-1:2], 2'b00};
         q_wdata[tail] <= fmt_wdata;
         q_be[tail]    <= fmt_be;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= offer && !fmt_legal;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Memory port: request held stable until acked, then one idle cycle.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE, ST_GAP: begin
               if (count != '0) begin
                  state      <= ST_REQ;
                  mem_wr_req <= 1'b1;
                  mem_addr   <= q_addr[head];
                  mem_wdata  <= q_wdata[head];
                  mem_be     <= q_be[head];
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  state      <= ST_GAP;
                  mem_wr_req <= 1'b0;
                  mem_be     <= 4'b0000;
               end
            end
            default: begin
               state      <= ST_IDLE;
               mem_wr_req <= 1'b0;
               mem_be     <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: vector table plus hand sequences,
// with a memory responder that checks every issued write against a scoreboard.
module tb_mem_store_unit;

   localparam int DEPTH      = 2;
   localparam int ADDR_WIDTH = 32;

   logic                  CLOCK = 1'b0;
   logic                  RESET = 1'b1;
   logic                  enable = 1'b0;
   logic [2:0]            opselect = 3'b000;
   logic [2:0]            operation = 3'b000;
   logic [ADDR_WIDTH-1:0] st_addr = '0;
   logic [31:0]           st_data = '0;
   logic                  stall;
   logic                  misalign_err;
   logic                  sq_empty;
   logic                  mem_wr_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_be;
   logic                  mem_ack = 1'b0;

   mem_store_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .opselect(opselect),
      .operation(operation), .st_addr(st_addr), .st_data(st_data),
      .stall(stall), .misalign_err(misalign_err), .sq_empty(sq_empty),
      .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic        legal;
      logic [31:0] wdata;
      logic [3:0]  be;
   } vec_t;

   wr_t  sb[$];
   wr_t  cur;
   bit   cur_valid = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   writes_seen = 0;
   int   req_age = 0;
   int   low_count = 0;
   int   last_gap = 0;
   int   ack_delay = 2;
   bit   hold_ack = 1'b0;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory responder: checks each new request against the scoreboard, checks
   // stability while waiting, and acks after ack_delay cycles unless held.
   always @(negedge CLOCK) begin
      if (RESET) begin
         mem_ack   = 1'b0;
         req_age   = 0;
         low_count = 0;
         cur_valid = 1'b0;
         sb.delete();
      end else begin
         if (mem_ack) mem_ack = 1'b0;
         if (!mem_wr_req) begin
            check("be_zero_when_idle", {28'h0, mem_be}, 32'h0);
            low_count++;
            req_age = 0;
         end else begin
            if (req_age == 0) begin
               writes_seen++;
               last_gap  = low_count;
               low_count = 0;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  cur_valid = 1'b0;
                  $display("FAIL unexpected_write: addr 0x%08h data 0x%08h be %b, none expected",
                           mem_addr, mem_wdata, mem_be);
               end else begin
                  cur = sb.pop_front();
                  cur_valid = 1'b1;
                  check("wr_addr", mem_addr, cur.addr);
                  check("wr_wdata", mem_wdata, cur.wdata);
                  check("wr_be", {28'h0, mem_be}, {28'h0, cur.be});
               end
            end else if (cur_valid) begin
               check("hold_addr", mem_addr, cur.addr);
               check("hold_wdata", mem_wdata, cur.wdata);
               check("hold_be", {28'h0, mem_be}, {28'h0, cur.be});
            end
            req_age++;
            if (!hold_ack && req_age > ack_delay) mem_ack = 1'b1;
         end
      end
   end

   task automatic do_reset();
      @(negedge CLOCK);
      RESET = 1'b1;
      @(negedge CLOCK);
      @(negedge CLOCK);
      RESET = 1'b0;
   endtask

   task automatic offer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic legal, input logic [31:0] wdata, input logic [3:0] be,
                        input logic exp_stall);
      wr_t w;
      @(negedge CLOCK);
      check("stall_at_offer", {31'h0, stall}, {31'h0, exp_stall});
      enable    = 1'b1;
      opselect  = 3'b100;
      operation = op;
      st_addr   = addr;
      st_data   = data;
      if (legal && !exp_stall) begin
         w.addr  = addr & 32'hFFFF_FFFC;
         w.wdata = wdata;
         w.be    = be;
         sb.push_back(w);
      end
      @(negedge CLOCK);
      enable = 1'b0;
      check("misalign_err", {31'h0, misalign_err}, {31'h0, !legal});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge CLOCK);
         if (sq_empty && sb.size() == 0) break;
      end
      check("sq_empty_at_idle", {31'h0, sq_empty}, 32'h1);
      check("scoreboard_drained", sb.size(), 32'h0);
   endtask

   task automatic wait_writes(input int target);
      for (int i = 0; i < 100 && writes_seen < target; i++) @(negedge CLOCK);
      check("writes_reached", writes_seen, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      vecs[0]  = '{3'b000, 32'h0000_0203, 32'h0000_00A5, 1'b1, 32'hA5A5_A5A5, 4'b1000};
      vecs[1]  = '{3'b000, 32'h0000_0200, 32'h1234_5677, 1'b1, 32'h7777_7777, 4'b0001};
      vecs[2]  = '{3'b000, 32'h0000_0101, 32'h0000_003C, 1'b1, 32'h3C3C_3C3C, 4'b0010};
      vecs[3]  = '{3'b001, 32'h0000_0302, 32'h0000_1234, 1'b1, 32'h1234_1234, 4'b1100};
      vecs[4]  = '{3'b001, 32'h0000_0300, 32'hFFFF_ABCD, 1'b1, 32'hABCD_ABCD, 4'b0011};
      vecs[5]  = '{3'b011, 32'h0000_0404, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 4'b1111};
      vecs[6]  = '{3'b001, 32'h0000_0301, 32'h0000_1234, 1'b0, 32'h0, 4'b0000};
      vecs[7]  = '{3'b011, 32'h0000_0306, 32'h1111_2222, 1'b0, 32'h0, 4'b0000};
      vecs[8]  = '{3'b011, 32'h0000_0302, 32'h3333_4444, 1'b0, 32'h0, 4'b0000};
      vecs[9]  = '{3'b010, 32'h0000_0100, 32'h5555_6666, 1'b0, 32'h0, 4'b0000};
      vecs[10] = '{3'b111, 32'h0000_0100, 32'h7777_8888, 1'b0, 32'h0, 4'b0000};
      vecs[11] = '{3'b011, 32'h8000_0FFC, 32'h0102_0304, 1'b1, 32'h0102_0304, 4'b1111};

      do_reset();
      check("rst_mem_wr_req", {31'h0, mem_wr_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", {28'h0, mem_be}, 32'h0);
      check("rst_misalign_err", {31'h0, misalign_err}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_sq_empty", {31'h0, sq_empty}, 32'h1);

      // SW into an empty unit: request appears one edge after acceptance.
      ack_delay = 2;
      offer(3'b011, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      check("latency_req_low", {31'h0, mem_wr_req}, 32'h0);
      check("latency_not_empty", {31'h0, sq_empty}, 32'h0);
      @(posedge CLOCK);
      #1;
      check("latency_req_high", {31'h0, mem_wr_req}, 32'h1);
      check("latency_addr", mem_addr, 32'h100);
      wait_idle();

      for (int i = 0; i < 12; i++) begin
         ack_delay = i % 3;
         base = writes_seen;
         offer(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].legal,
               vecs[i].wdata, vecs[i].be, 1'b0);
         if (vecs[i].legal) begin
            wait_idle();
            check("vec_write_count", writes_seen, base + 1);
         end else begin
            @(negedge CLOCK);
            check("misalign_err_one_pulse", {31'h0, misalign_err}, 32'h0);
            repeat (3) @(negedge CLOCK);
            check("reject_no_write", writes_seen, base);
            check("reject_sq_empty", {31'h0, sq_empty}, 32'h1);
         end
      end

      // Non-store opselect is ignored entirely, even with a misaligned SW.
      base = writes_seen;
      @(negedge CLOCK);
      enable = 1'b1; opselect = 3'b010; operation = 3'b011; st_addr = 32'h306;
      @(negedge CLOCK);
      enable = 1'b0; opselect = 3'b000;
      check("nonstore_no_err", {31'h0, misalign_err}, 32'h0);
      repeat (3) @(negedge CLOCK);
      check("nonstore_no_write", writes_seen, base);
      check("nonstore_sq_empty", {31'h0, sq_empty}, 32'h1);

      // Fill the queue with ack held, see stall, then drain in order.
      hold_ack  = 1'b1;
      ack_delay = 0;
      base = writes_seen;
      offer(3'b011, 32'h10, 32'h1010_1010, 1'b1, 32'h1010_1010, 4'b1111, 1'b0);
      offer(3'b011, 32'h14, 32'h1414_1414, 1'b1, 32'h1414_1414, 4'b1111, 1'b0);
      offer(3'b011, 32'h18, 32'h1818_1818, 1'b1, 32'h1818_1818, 4'b1111, 1'b1);
      check("full_stall_held", {31'h0, stall}, 32'h1);
      check("full_req_held", {31'h0, mem_wr_req}, 32'h1);
      hold_ack = 1'b0;
      wait_writes(base + 2);
      check("gap_one_cycle", last_gap, 32'h1);
      offer(3'b011, 32'h18, 32'h1818_1818, 1'b1, 32'h1818_1818, 4'b1111, 1'b0);
      wait_idle();
      check("full_seq_writes", writes_seen, base + 3);

      // Error takes priority over stall when the queue is full.
      hold_ack = 1'b1;
      offer(3'b000, 32'h40, 32'h0000_0011, 1'b1, 32'h1111_1111, 4'b0001, 1'b0);
      offer(3'b000, 32'h41, 32'h0000_0022, 1'b1, 32'h2222_2222, 4'b0010, 1'b0);
      offer(3'b001, 32'h43, 32'h0000_9999, 1'b0, 32'h0, 4'b0000, 1'b1);
      check("midreset_req_before", {31'h0, mem_wr_req}, 32'h1);
      check("midreset_stall_before", {31'h0, stall}, 32'h1);

      // Reset abandons the outstanding write and the queued entry.
      do_reset();
      hold_ack  = 1'b0;
      ack_delay = 1;
      check("midreset_req", {31'h0, mem_wr_req}, 32'h0);
      check("midreset_be", {28'h0, mem_be}, 32'h0);
      check("midreset_sq_empty", {31'h0, sq_empty}, 32'h1);
      check("midreset_stall", {31'h0, stall}, 32'h0);
      base = writes_seen;
      repeat (4) @(negedge CLOCK);
      check("midreset_no_write", writes_seen, base);
      offer(3'b000, 32'h42, 32'h0000_0055, 1'b1, 32'h5555_5555, 4'b0100, 1'b0);
      wait_idle();
      check("post_reset_write", writes_seen, base + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
